// File: rtl/hs_sink_synch_pkg.sv
// Shared types and limits for the sink end of the req/ack word crossing.
package hs_sink_synch_pkg;

  typedef enum logic [1:0] {IDLE, VALID, ACK} hs_sink_state_t;

  localparam int SNC_WID_MIN = 2;
  localparam int SNC_WID_MAX = 4;

  function automatic bit snc_wid_legal(input int wid);
    return (wid >= SNC_WID_MIN) && (wid <= SNC_WID_MAX);
  endfunction

endpackage

// File: rtl/sink_req_synch.sv
// Single-bit multi-flop synchronizer into sink_clk; reset clears every stage.
module sink_req_synch
  import hs_sink_synch_pkg::*;
#(
  parameter int SNC_WID = 2
) (
  input  logic sink_clk,
  input  logic sink_rst,
  input  logic raw,
  output logic synced
);

  logic [SNC_WID-1:0] stage_reg;

  // Stage 0 is the only flop that ever looks at the asynchronous input.
  always_ff @(posedge sink_clk or posedge sink_rst) begin
    if (sink_rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[SNC_WID-2:0], raw};
    end
  end

  assign synced = stage_reg[SNC_WID-1];

endmodule

// File: rtl/hs_sink_synch.sv
// Sink side of a 4-phase req/ack handshake: synchronizes source_req, captures
// the source-held word and hands it to sink logic over valid/ready.
module hs_sink_synch
  import hs_sink_synch_pkg::*;
#(
  parameter int DAT_WID = 8,
  parameter int SNC_WID = 2
) (
  input  logic               sink_clk,
  input  logic               sink_rst,
  input  logic               source_req,
  input  logic [DAT_WID-1:0] source_dat,
  output logic               sink_ack,
  output logic               sink_vld,
  input  logic               sink_rdy,
  output logic [DAT_WID-1:0] sink_dat,
  output logic               sink_busy,
  output logic               sink_err
);

  if (!snc_wid_legal(SNC_WID)) begin : g_bad_snc_wid
    $error("hs_sink_synch: SNC_WID=%0d outside %0d..%0d", SNC_WID, SNC_WID_MIN, SNC_WID_MAX);
  end

  logic               req_s;
  logic               req_prev_reg;
  hs_sink_state_t     state_reg;
  hs_sink_state_t     state_next;
  logic               vld_reg;
  logic               ack_reg;
  logic [DAT_WID-1:0] dat_reg;
  logic               err_reg;

  sink_req_synch #(
    .SNC_WID (SNC_WID)
  ) u_req_synch (
    .sink_clk (sink_clk),
    .sink_rst (sink_rst),
    .raw      (source_req),
    .synced   (req_s)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_s)    state_next = VALID;
      VALID:   if (sink_rdy) state_next = ACK;
      ACK:     if (!req_s)   state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // vld/ack come from flops loaded with the next-state decode so the
  // source domain never sees a combinational glitch on sink_ack.
  always_ff @(posedge sink_clk or posedge sink_rst) begin
    if (sink_rst) begin
      state_reg    <= IDLE;
      vld_reg      <= 1'b0;
      ack_reg      <= 1'b0;
      dat_reg      <= '0;
      err_reg      <= 1'b0;
      req_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      vld_reg      <= (state_next == VALID);
      ack_reg      <= (state_next == ACK);
      req_prev_reg <= req_s;
      // source_dat has been stable for the whole synchronizer delay here.
      if (state_reg == IDLE && req_s) begin
        dat_reg <= source_dat;
      end
      // A falling req_s during VALID means the source withdrew before ack.
      err_reg <= (state_reg == VALID) && req_prev_reg && !req_s;
    end
  end

  assign sink_vld  = vld_reg;
  assign sink_ack  = ack_reg;
  assign sink_dat  = dat_reg;
  assign sink_err  = err_reg;
  assign sink_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_hs_sink_synch.sv
// Directed bench for hs_sink_synch: scoreboarded word delivery plus latency,
// backpressure, protocol-error, reset and SNC_WID=4 checks.
module tb_hs_sink_synch;

  logic       clk = 1'b0;
  logic       rst;
  logic       req, rdy;
  logic [7:0] dat;
  logic       ack, vld, busy, err;
  logic [7:0] sdat;
  logic       req4, rdy4;
  logic [7:0] dat4;
  logic       ack4, vld4, busy4, err4;
  logic [7:0] sdat4;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int beats = 0;
  int err_pulses = 0;

  always #5 clk = ~clk;

  hs_sink_synch #(.DAT_WID(8), .SNC_WID(2)) dut (
    .sink_clk(clk), .sink_rst(rst), .source_req(req), .source_dat(dat),
    .sink_ack(ack), .sink_vld(vld), .sink_rdy(rdy), .sink_dat(sdat),
    .sink_busy(busy), .sink_err(err)
  );

  hs_sink_synch #(.DAT_WID(8), .SNC_WID(4)) dut4 (
    .sink_clk(clk), .sink_rst(rst), .source_req(req4), .source_dat(dat4),
    .sink_ack(ack4), .sink_vld(vld4), .sink_rdy(rdy4), .sink_dat(sdat4),
    .sink_busy(busy4), .sink_err(err4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return vld;
      1:       return ack;
      2:       return vld4;
      default: return ack4;
    endcase
  endfunction

  // Returns the number of edges until the chosen output equals val, or -1.
  task automatic wait_sig(input int which, input logic val, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (pick(which) === val) begin
        n = i;
        break;
      end
    end
  endtask

  // Scoreboard side: every accepted beat must match the oldest pending word.
  always @(negedge clk) begin
    if (!rst && vld && rdy) begin
      beats++;
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("beat_dat", 32'(sdat), 32'(exp_q.pop_front()));
    end
    if (err) err_pulses++;
  end

  initial begin
    int n;
    int e0;
    logic busy_ok;
    rst = 1'b1; req = 1'b0; rdy = 1'b1; dat = 8'h00;
    req4 = 1'b0; rdy4 = 1'b1; dat4 = 8'h00;
    #1;
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", 32'(sdat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Basic transfer
    dat = 8'hA5; req = 1'b1; exp_q.push_back(8'hA5);
    wait_sig(0, 1'b1, 10, n);
    check("basic_vld_latency", 32'(n), 32'd3);
    check("basic_dat", 32'(sdat), 32'hA5);
    tick();
    check("basic_ack_rise", 32'(ack), 32'd1);
    check("basic_vld_drop", 32'(vld), 32'd0);
    req = 1'b0;
    wait_sig(1, 1'b0, 10, n);
    check("basic_ack_fall_latency", 32'(n), 32'd3);
    check("basic_busy_idle", 32'(busy), 32'd0);

    // Backpressure
    rdy = 1'b0; dat = 8'h3C; req = 1'b1; exp_q.push_back(8'h3C);
    wait_sig(0, 1'b1, 10, n);
    check("bp_vld_latency", 32'(n), 32'd3);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_vld_hold", 32'(vld), 32'd1);
      check("bp_dat_hold", 32'(sdat), 32'h3C);
      check("bp_ack_low", 32'(ack), 32'd0);
    end
    rdy = 1'b1;
    tick();
    check("bp_ack_rise", 32'(ack), 32'd1);
    req = 1'b0;
    wait_sig(1, 1'b0, 10, n);
    check("bp_ack_fall_latency", 32'(n), 32'd3);

    // Back-to-back words
    e0 = err_pulses;
    for (int w = 1; w <= 4; w++) begin
      dat = 8'(w); req = 1'b1; exp_q.push_back(8'(w));
      wait_sig(1, 1'b1, 12, n);
      check("b2b_ack_seen", 32'(n > 0), 32'd1);
      req = 1'b0;
      wait_sig(1, 1'b0, 12, n);
      check("b2b_ack_low", 32'(n > 0), 32'd1);
    end
    tick(); tick(); tick();
    check("b2b_beats", 32'(beats), 32'd6);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    check("b2b_no_err", 32'(err_pulses - e0), 32'd0);

    // Protocol error: source withdraws while word is still pending
    rdy = 1'b0; dat = 8'h5A; req = 1'b1; exp_q.push_back(8'h5A);
    e0 = err_pulses;
    wait_sig(0, 1'b1, 10, n);
    check("perr_vld_latency", 32'(n), 32'd3);
    tick(); tick();
    req = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("perr_err_pulse", 32'(err_pulses - e0), 32'd1);
    check("perr_vld_kept", 32'(vld), 32'd1);
    check("perr_dat_kept", 32'(sdat), 32'h5A);
    rdy = 1'b1;
    tick();
    check("perr_ack_pulse", 32'(ack), 32'd1);
    tick();
    check("perr_ack_end", 32'(ack), 32'd0);
    check("perr_busy_idle", 32'(busy), 32'd0);
    check("perr_beats", 32'(beats), 32'd7);

    // Reset mid-transfer
    rdy = 1'b0; dat = 8'hFF; req = 1'b1; exp_q.push_back(8'hFF);
    wait_sig(0, 1'b1, 10, n);
    check("rst_mid_vld", 32'(n), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_vld0", 32'(vld), 32'd0);
    check("rst_mid_ack0", 32'(ack), 32'd0);
    check("rst_mid_dat0", 32'(sdat), 32'd0);
    check("rst_mid_busy0", 32'(busy), 32'd0);
    exp_q.delete();
    req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("rst_rel_busy", 32'(busy), 32'd0);
    check("rst_rel_vld", 32'(vld), 32'd0);
    rdy = 1'b1;

    // SNC_WID=4 instance
    dat4 = 8'hC3; req4 = 1'b1;
    wait_sig(2, 1'b1, 12, n);
    check("w4_vld_latency", 32'(n), 32'd5);
    check("w4_dat", 32'(sdat4), 32'hC3);
    check("w4_busy_vld", 32'(busy4), 32'd1);
    tick();
    check("w4_ack_rise", 32'(ack4), 32'd1);
    req4 = 1'b0;
    busy_ok = 1'b1;
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ack4 === 1'b0) begin
        n = i;
        break;
      end
      if (busy4 !== 1'b1) busy_ok = 1'b0;
    end
    check("w4_ack_fall_latency", 32'(n), 32'd5);
    check("w4_busy_during_ack", 32'(busy_ok), 32'd1);
    check("w4_busy_idle", 32'(busy4), 32'd0);
    check("w4_no_err", 32'(err4), 32'd0);

    check("final_err_pulses", 32'(err_pulses), 32'd1);
    check("final_beats", 32'(beats), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_sink_synch.md
Name: hs_sink_synch

Overview:
Sink-domain end of a 4-phase req/ack bus handshake for crossing a multi-bit word from a source clock domain into sink_clk.
- Synchronizes the asynchronous source_req and captures the source-held source_dat.
- Presents the word to sink logic on a valid/ready interface.
- Returns a registered sink_ack, which the source domain synchronizes on its own side.
- One instance per crossing; the source-side requester is a separate block.

Parameters:
DAT_WID, 8, width in bits of the transferred word
SNC_WID, 2, synchronizer stages on source_req (legal range 2..4; elaboration error outside range)

Ports:
sink_clk  input  1  sink core clock
sink_rst  input  1  sink core reset, asynchronous, active-high
source_req  input  1  request from source domain, asynchronous to sink_clk
source_dat  input  DAT_WID  source word; stable from before source_req rises until source sees sink_ack high
sink_ack  output  1  acknowledge to source domain, driven directly from a flop
sink_vld  output  1  word available on sink_dat
sink_rdy  input  1  sink logic accepts word when high with sink_vld
sink_dat  output  DAT_WID  captured word
sink_busy  output  1  high whenever FSM is not IDLE
sink_err  output  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (async assert, sync-to-clock deassert handled upstream): all synchronizer stages 0, FSM IDLE, sink_ack 0, sink_vld 0, sink_dat 0, sink_busy 0, sink_err 0.
- req_s = last stage of an SNC_WID-flop chain clocked by sink_clk; stage 0 samples source_req. No other logic may sample source_req.
- source_dat is sampled only on the IDLE->VALID transition. The chain delay plus the source hold rule make this safe.
- FSM states: IDLE, VALID, ACK.
- IDLE: when req_s=1, the next edge loads sink_dat<=source_dat, sets sink_vld=1 and goes to VALID.
- VALID: sink_vld=1. On an edge with sink_rdy=1, sink_vld->0, sink_ack->1, go to ACK. Otherwise hold; sink_dat is stable.
- ACK: sink_ack=1. On an edge with req_s=0, sink_ack->0, go to IDLE. In IDLE, sink_ack=0.
- Latency: source_req sampled high at edge 0 -> req_s high after edge SNC_WID-1 -> sink_vld high after edge SNC_WID.
  - That is SNC_WID+1 edges from first sampling (3 for SNC_WID=2).
  - With sink_rdy tied high, sink_ack rises one edge after sink_vld.
  - After req_s falls, sink_ack falls one edge later.
- A new transfer cannot start until ACK->IDLE. A re-raised req is seen only from IDLE, so there are no back-to-back duplicates.
- Outputs in each state: sink_vld = (state==VALID); sink_ack = (state==ACK); both registered, not decoded combinationally. sink_busy = (state!=IDLE).
- Protocol error: if req_s falls while in VALID (source withdrew before ack), sink_err pulses for 1 cycle on the edge following detection.
  - The captured word is still delivered.
  - On accept the FSM enters ACK; since req_s is already 0, it returns to IDLE on the next edge (1-cycle ack pulse).
- sink_dat holds its last value outside VALID; it changes only on capture.
- Reset mid-transfer: everything returns to reset values immediately and the pending word is discarded. If source_req is still high after release, it is captured as a new transfer. The system requires source and sink resets to be related so that this is acceptable.
- sink_rdy is ignored outside VALID.

Decomposition:
- Package hs_sink_synch_pkg holds:
  - typedef enum logic [1:0] {IDLE, VALID, ACK} hs_sink_state_t;
  - localparams SNC_WID_MIN=2 and SNC_WID_MAX=4.
- Sub-module sink_req_synch: a 1-bit SNC_WID-stage flop chain on sink_clk/sink_rst with reset value 0. It is reused for any other single-bit crossing.
- Top level holds the FSM, the capture register and the error pulse.

Test Plan:
- Basic transfer: DAT_WID=8, SNC_WID=2, sink_rdy=1; source_dat=8'hA5, source_req rises -> sink_vld high 3 edges after first sampled-high req with sink_dat=8'hA5; sink_ack high the next edge; drop req -> sink_ack low 3 edges after req falls.
- Backpressure: sink_rdy=0 for 10 cycles after sink_vld -> sink_vld/sink_dat=8'h3C hold for 10 cycles, sink_ack stays 0; sink_rdy=1 -> ack 1 edge later.
- Back-to-back: 4 words 8'h01..8'h04, each req raised only after ack seen low -> exactly 4 sink_vld&&sink_rdy beats in order, no duplicates, sink_err never pulses.
- Protocol error: req drops after 2 cycles in VALID -> sink_err 1-cycle pulse, word still delivered, sink_ack 1-cycle pulse, FSM back to IDLE.
- Reset mid-operation: assert sink_rst while in VALID with 8'hFF -> sink_vld, sink_ack, sink_dat, sink_busy all 0 immediately, asynchronously; release with req low -> stays IDLE.
- SNC_WID=4 sweep: latency from first sampled-high req to sink_vld = 5 edges; sink_busy high for the whole transfer.
